// File: rtl/keccak_byte_packer_if.sv
// keccak_byte_packer_if: byte-stream input and keccak word-port signal group.
// master drives bytes and back-pressure; slave is the packer.
interface keccak_byte_packer_if;
   logic [7:0]  byte_in;
   logic        byte_valid;
   logic        byte_last;
   logic        empty_msg;
   logic        byte_ready;
   logic        buffer_full;
   logic [31:0] k_in;
   logic        k_in_ready;
   logic        k_is_last;
   logic [1:0]  k_byte_num;
   modport master (
      output byte_in, byte_valid, byte_last, empty_msg, buffer_full,
      input  byte_ready, k_in, k_in_ready, k_is_last, k_byte_num
   );
   modport slave (
      input  byte_in, byte_valid, byte_last, empty_msg, buffer_full,
      output byte_ready, k_in, k_in_ready, k_is_last, k_byte_num
   );
endinterface

// File: rtl/keccak_byte_packer.sv
// keccak_byte_packer: packs a byte stream MSB-first into 32-bit keccak words,
// generating the core's is_last/byte_num final-word convention.
module keccak_byte_packer #(
   parameter int CNT_W = 32
) (
   input  logic                 clk,
   input  logic                 reset,
   keccak_byte_packer_if.slave  bus,
   output logic [CNT_W-1:0]     msg_len
);
   typedef enum logic [1:0] {FILL, SEND, TAIL} state_t;
   state_t      state, state_nx;
   logic [1:0]  cnt;
   logic [31:0] word;
   logic        pend_last;
   logic [2:0]  pend_n;
   logic        new_msg;
   logic        accept, empty_go, strobe, word_done, last_word;
   assign accept    = state == FILL && bus.byte_valid;
   assign word_done = accept && (cnt == 2'd3 || bus.byte_last);
   assign empty_go  = state == FILL && !bus.byte_valid && bus.empty_msg && cnt == 2'd0;
   assign strobe    = state != FILL && !bus.buffer_full;
   // A full final word is sent as not-last; TAIL then carries the empty last word.
   assign last_word = state == TAIL || (state == SEND && pend_last && pend_n != 3'd4);
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= FILL;
      else       state <= state_nx;
   end
   always_comb begin
      state_nx = state == FILL ? (word_done ? SEND : empty_go ? TAIL : FILL)
               : !strobe ? state
               : (state == SEND && pend_last && pend_n == 3'd4) ? TAIL : FILL;
   end
   always_comb begin
      bus.byte_ready = state == FILL;
      bus.k_in_ready = strobe;
      bus.k_in       = state == SEND ? word : 32'd0;
      bus.k_is_last  = strobe && last_word;
      bus.k_byte_num = (strobe && state == SEND && last_word) ? pend_n[1:0] : 2'd0;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt       <= 2'd0;
         word      <= 32'd0;
         pend_last <= 1'b0;
         pend_n    <= 3'd0;
         msg_len   <= '0;
         new_msg   <= 1'b1;
      end else begin
         if (accept) begin
            word    <= word | ({bus.byte_in, 24'd0} >> {cnt, 3'd0});
            cnt     <= cnt + 2'd1;
            msg_len <= new_msg ? CNT_W'(1) : (&msg_len ? msg_len : msg_len + CNT_W'(1));
            new_msg <= 1'b0;
         end
         if (word_done) begin
            pend_last <= bus.byte_last;
            pend_n    <= {1'b0, cnt} + 3'd1;
         end
         if (empty_go) msg_len <= '0;
         if (strobe && state == SEND) begin
            word <= 32'd0;
            cnt  <= 2'd0;
         end
         if (strobe && last_word) new_msg <= 1'b1;
      end
   end
endmodule
